// File: rtl/sttx_pkg.sv
// Shared definitions for the TCAM status-merge engine: segment status codes,
// engine state encoding and the per-segment merge decision.
package sttx_pkg;

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_VALID = 2'b01;
   localparam logic [1:0] ST_MOD   = 2'b10;
   localparam logic [1:0] ST_WILD  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      EV_NONE  = 2'd0,
      EV_ALLOC = 2'd1,
      EV_HIT   = 2'd2,
      EV_MOD   = 2'd3
   } evt_e;

   // use_id selects the ID data bits for the result, st is the result status
   typedef struct packed {
      logic       use_id;
      logic [1:0] st;
      evt_e       evt;
   } merge_t;

   // The decision depends only on the two status fields and whether the data
   // fields match, so it stays independent of the data width.
   function automatic merge_t seg_merge(input logic [1:0] ram_st,
                                        input logic [1:0] id_st,
                                        input logic       data_eq);
      merge_t m;
      m.use_id = 1'b0;
      m.st     = ram_st;
      m.evt    = EV_NONE;
      if ((id_st == ST_WILD) || (ram_st == ST_WILD)) begin
         m.evt = EV_NONE;
      end else if (ram_st == ST_EMPTY) begin
         m.use_id = 1'b1;
         m.st     = ST_VALID;
         m.evt    = EV_ALLOC;
      end else if (data_eq) begin
         m.evt = EV_HIT;
      end else begin
         m.use_id = 1'b1;
         m.st     = ST_MOD;
         m.evt    = EV_MOD;
      end
      return m;
   endfunction

endpackage

// File: rtl/sttx_seg_merge.sv
// Combinational merge cell for one segment: RAM segment + ID segment ->
// merged segment and the counter event it produces.
module sttx_seg_merge
   import sttx_pkg::*;
#(
   parameter int DWID = 8
) (
   input  logic [DWID+1:0] ram_seg_i,
   input  logic [DWID+1:0] id_seg_i,
   output logic [DWID+1:0] seg_o,
   output evt_e            evt_o
);

   merge_t m;

   // Apply the merge priority and assemble the output segment
   always_comb begin
      m     = seg_merge(ram_seg_i[DWID+1:DWID], id_seg_i[DWID+1:DWID],
                        ram_seg_i[DWID-1:0] == id_seg_i[DWID-1:0]);
      seg_o = {m.st, (m.use_id ? id_seg_i[DWID-1:0] : ram_seg_i[DWID-1:0])};
      evt_o = m.evt;
   end

endmodule

// File: rtl/sttx_status_engine_par.sv
// Multi-lane status merge engine. Captures a set-ID vector and the matching
// RAM vector, merges LANES segments per beat and publishes the merged vector
// with alloc/hit/mod counts when the operation completes.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | ready for a request; inputs captured on the accept edge
//   S_RUN  | one beat per edge, LANES segments each; abort returns to idle
//   S_DONE | results published, o_Done high for this single cycle
module sttx_status_engine_par
   import sttx_pkg::*;
#(
   parameter  int KWID   = 104,
   parameter  int DWID   = 8,
   parameter  int LANES  = 1,
   localparam int SEGWID = DWID + 2,
   localparam int NSEG   = KWID / DWID,
   localparam int VTWID  = SEGWID * NSEG,
   localparam int NBEAT  = (NSEG + LANES - 1) / LANES,
   localparam int CWID   = $clog2(NSEG + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_Status_En,
   output logic             o_ready,
   input  logic             i_abort,
   input  logic [VTWID-1:0] i_SET_ID,
   input  logic [VTWID-1:0] i_RAM_Data,
   output logic [VTWID-1:0] o_SETID_MOD,
   output logic             o_Done,
   output logic             o_busy,
   output logic [CWID-1:0]  o_alloc_cnt,
   output logic [CWID-1:0]  o_hit_cnt,
   output logic [CWID-1:0]  o_mod_cnt
);

   // Working vectors are padded to a whole number of beats so the last beat
   // never indexes outside the vector; padded lanes are simply not counted.
   localparam int PADW = NBEAT * LANES * SEGWID;
   localparam int IW   = $clog2(PADW);
   localparam int BWID = (NBEAT > 1) ? $clog2(NBEAT) : 1;

   state_e            state_q;
   logic [BWID-1:0]   beat_q;
   logic [PADW-1:0]   id_q, ram_q, work_q, work_d;
   logic [CWID-1:0]   alloc_q, hit_q, mod_q;
   logic [CWID-1:0]   alloc_d, hit_d, mod_d;
   logic [VTWID-1:0]  setid_q;
   logic [CWID-1:0]   alloc_out_q, hit_out_q, mod_out_q;
   logic              ready_q, busy_q, done_q;
   logic              last_beat;

   logic [31:0]       lane_seg [LANES];
   logic [IW-1:0]     lane_off [LANES];
   logic [SEGWID-1:0] lane_ram [LANES];
   logic [SEGWID-1:0] lane_id  [LANES];
   logic [SEGWID-1:0] lane_out [LANES];
   evt_e              lane_evt [LANES];
   logic [LANES-1:0]  lane_vld;

   assign last_beat = (beat_q == BWID'(NBEAT - 1));

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_seg[l] = 32'(beat_q) * 32'(LANES) + 32'(l);
      assign lane_off[l] = IW'(lane_seg[l] * 32'(SEGWID));
      assign lane_vld[l] = (lane_seg[l] < 32'(NSEG));
      assign lane_ram[l] = ram_q[lane_off[l] +: SEGWID];
      assign lane_id[l]  = id_q[lane_off[l] +: SEGWID];

      sttx_seg_merge #(.DWID(DWID)) u_merge (
         .ram_seg_i (lane_ram[l]),
         .id_seg_i  (lane_id[l]),
         .seg_o     (lane_out[l]),
         .evt_o     (lane_evt[l])
      );
   end

   // Fold this beat's lane results into the working vector and counters
   always_comb begin
      work_d  = work_q;
      alloc_d = alloc_q;
      hit_d   = hit_q;
      mod_d   = mod_q;
      for (int l = 0; l < LANES; l++) begin
         if (lane_vld[l]) begin
            work_d[lane_off[l] +: SEGWID] = lane_out[l];
            alloc_d = alloc_d + CWID'(lane_evt[l] == EV_ALLOC);
            hit_d   = hit_d   + CWID'(lane_evt[l] == EV_HIT);
            mod_d   = mod_d   + CWID'(lane_evt[l] == EV_MOD);
         end
      end
   end

   // Engine sequencing, capture, beat stepping and result publication
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         id_q        <= '0;
         ram_q       <= '0;
         work_q      <= '0;
         alloc_q     <= '0;
         hit_q       <= '0;
         mod_q       <= '0;
         setid_q     <= '0;
         alloc_out_q <= '0;
         hit_out_q   <= '0;
         mod_out_q   <= '0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (i_Status_En) begin
                  id_q    <= PADW'(i_SET_ID);
                  ram_q   <= PADW'(i_RAM_Data);
                  work_q  <= '0;
                  alloc_q <= '0;
                  hit_q   <= '0;
                  mod_q   <= '0;
                  beat_q  <= '0;
                  state_q <= S_RUN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (i_abort) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  work_q  <= work_d;
                  alloc_q <= alloc_d;
                  hit_q   <= hit_d;
                  mod_q   <= mod_d;
                  if (last_beat) begin
                     setid_q     <= work_d[VTWID-1:0];
                     alloc_out_q <= alloc_d;
                     hit_out_q   <= hit_d;
                     mod_out_q   <= mod_d;
                     done_q      <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     beat_q <= beat_q + BWID'(1);
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready     = ready_q;
   assign o_busy      = busy_q;
   assign o_Done      = done_q;
   assign o_SETID_MOD = setid_q;
   assign o_alloc_cnt = alloc_out_q;
   assign o_hit_cnt   = hit_out_q;
   assign o_mod_cnt   = mod_out_q;

endmodule
